// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable, sync/blank/de and x/y counters, two vertical modes.
// Define VIDEO_TIMING_TESTPAT_EN to add an 8-bar colour test pattern on r/g/b.
module video_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACT0   = 480,
  parameter int unsigned V_FP0    = 10,
  parameter int unsigned V_SYNC0  = 2,
  parameter int unsigned V_BP0    = 33,
  parameter int unsigned V_ACT1   = 576,
  parameter int unsigned V_FP1    = 5,
  parameter int unsigned V_SYNC1  = 5,
  parameter int unsigned V_BP1    = 39,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned X_W      = 12,
  parameter int unsigned Y_W      = 11
) (
  input  logic           clk,
  input  logic           reset_in,
  input  logic           mode,
  output logic           ce_pixel,
  output logic           hs,
  output logic           vs,
  output logic           hblank,
  output logic           vblank,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
`ifdef VIDEO_TIMING_TESTPAT_EN
  output logic [7:0]     r,
  output logic [7:0]     g,
  output logic [7:0]     b,
`endif
  output logic           cur_mode
);

  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal0 = V_ACT0 + V_FP0 + V_SYNC0 + V_BP0;
  localparam int unsigned VTotal1 = V_ACT1 + V_FP1 + V_SYNC1 + V_BP1;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [X_W-1:0]  XLast   = X_W'(HTotal - 1);
  localparam logic [X_W-1:0]  XAct    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]  XSyncS  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]  XSyncE  = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]  YLast0  = Y_W'(VTotal0 - 1);
  localparam logic [Y_W-1:0]  YLast1  = Y_W'(VTotal1 - 1);
  localparam logic [Y_W-1:0]  YAct0   = Y_W'(V_ACT0);
  localparam logic [Y_W-1:0]  YAct1   = Y_W'(V_ACT1);
  localparam logic [Y_W-1:0]  YSyncS0 = Y_W'(V_ACT0 + V_FP0);
  localparam logic [Y_W-1:0]  YSyncS1 = Y_W'(V_ACT1 + V_FP1);
  localparam logic [Y_W-1:0]  YSyncE0 = Y_W'(V_ACT0 + V_FP0 + V_SYNC0);
  localparam logic [Y_W-1:0]  YSyncE1 = Y_W'(V_ACT1 + V_FP1 + V_SYNC1);

  logic [DivW-1:0] div_q, div_d;
  logic            ce_q, ce_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic            mode_q, mode_d;
  logic            fs_q, fs_d;
  logic            hs_q, hs_d, vs_q, vs_d;
  logic            hb_q, hb_d, vb_q, vb_d, de_q, de_d;
  logic [Y_W-1:0]  y_last, y_act, y_sync_s, y_sync_e;

`ifdef VIDEO_TIMING_TESTPAT_EN
  localparam logic [X_W-1:0] BarW = X_W'(H_ACTIVE / 8);
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [2:0] bar;
`endif

  always_comb begin
    div_d  = (div_q == DivLast) ? '0 : div_q + DivW'(1);
    ce_d   = (div_q == DivLast);
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    fs_d   = 1'b0;
    y_last = mode_q ? YLast1 : YLast0;
    if (ce_q) begin
      if (x_q == XLast) begin
        x_d = '0;
        if (y_q >= y_last) begin
          // Frame wrap: the only point where a new mode is accepted.
          y_d    = '0;
          mode_d = mode;
          fs_d   = 1'b1;
        end else begin
          y_d = y_q + Y_W'(1);
        end
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
    // Decode from next-state counters so the registered flags line up with the new x/y.
    y_act    = mode_d ? YAct1   : YAct0;
    y_sync_s = mode_d ? YSyncS1 : YSyncS0;
    y_sync_e = mode_d ? YSyncE1 : YSyncE0;
    hb_d     = (x_d >= XAct);
    vb_d     = (y_d >= y_act);
    de_d     = ~(hb_d | vb_d);
    hs_d     = ((x_d >= XSyncS) && (x_d < XSyncE)) ? HS_POL : ~HS_POL;
    vs_d     = ((y_d >= y_sync_s) && (y_d < y_sync_e)) ? VS_POL : ~VS_POL;
`ifdef VIDEO_TIMING_TESTPAT_EN
    bar = 3'(x_d / BarW);
    r_d = de_d ? {8{~bar[1]}} : 8'h00;
    g_d = de_d ? {8{~bar[2]}} : 8'h00;
    b_d = de_d ? {8{~bar[0]}} : 8'h00;
`endif
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      div_q  <= '0;
      ce_q   <= 1'b0;
      x_q    <= XLast;
      y_q    <= YLast0;
      mode_q <= 1'b0;
      fs_q   <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      hb_q   <= 1'b1;
      vb_q   <= 1'b1;
      de_q   <= 1'b0;
`ifdef VIDEO_TIMING_TESTPAT_EN
      r_q    <= 8'h00;
      g_q    <= 8'h00;
      b_q    <= 8'h00;
`endif
    end else begin
      div_q  <= div_d;
      ce_q   <= ce_d;
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      fs_q   <= fs_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      hb_q   <= hb_d;
      vb_q   <= vb_d;
      de_q   <= de_d;
`ifdef VIDEO_TIMING_TESTPAT_EN
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
`endif
    end
  end

  assign ce_pixel    = ce_q;
  assign x           = x_q;
  assign y           = y_q;
  assign cur_mode    = mode_q;
  assign frame_start = fs_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign hblank      = hb_q;
  assign vblank      = vb_q;
  assign de          = de_q;
`ifdef VIDEO_TIMING_TESTPAT_EN
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen: a linear-pixel-index frame model feeds a scoreboard queue
// that a negedge monitor drains and compares against every DUT output.
module tb_video_timing_gen;

  localparam int unsigned CD  = 2;
  localparam int unsigned HA  = 16;
  localparam int unsigned HFP = 2;
  localparam int unsigned HSY = 3;
  localparam int unsigned HBP = 3;
  localparam int unsigned HT  = HA + HFP + HSY + HBP;
  localparam int unsigned VA0 = 8,  VF0 = 1, VS0 = 2, VB0 = 2;
  localparam int unsigned VA1 = 10, VF1 = 2, VS1 = 1, VB1 = 3;
  localparam int unsigned VT0 = VA0 + VF0 + VS0 + VB0;
  localparam int unsigned VT1 = VA1 + VF1 + VS1 + VB1;
  localparam int unsigned NCYC = 12000;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        mode = 1'b0;
  logic        ce_pixel, hs, vs, hblank, vblank, de, frame_start, cur_mode;
  logic [11:0] x;
  logic [10:0] y;
`ifdef VIDEO_TIMING_TESTPAT_EN
  logic [7:0]  r, g, b;
`endif

  video_timing_gen #(
    .CLK_DIV (CD),  .H_ACTIVE(HA),  .H_FP   (HFP), .H_SYNC (HSY), .H_BP(HBP),
    .V_ACT0  (VA0), .V_FP0   (VF0), .V_SYNC0(VS0), .V_BP0  (VB0),
    .V_ACT1  (VA1), .V_FP1   (VF1), .V_SYNC1(VS1), .V_BP1  (VB1),
    .HS_POL  (1'b0), .VS_POL (1'b0), .X_W   (12),  .Y_W    (11)
  ) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .mode       (mode),
    .ce_pixel   (ce_pixel),
    .hs         (hs),
    .vs         (vs),
    .hblank     (hblank),
    .vblank     (vblank),
    .de         (de),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
`ifdef VIDEO_TIMING_TESTPAT_EN
    .r          (r),
    .g          (g),
    .b          (b),
`endif
    .cur_mode   (cur_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ce; int x; int y; int hs; int vs; int hb; int vb; int de; int fs; int cm; int rgb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: edges since reset release, pixel index within the frame, mode in effect.
  int   m_e;
  int   m_p;
  int   m_cm;
  bit   m_ce;
  bit   m_fs;

  function automatic int vtot(input int cm);
    return (cm != 0) ? VT1 : VT0;
  endfunction

  function automatic int bar_rgb(input int px);
    int colours[8];
    colours = '{32'hFFFFFF, 32'hFFFF00, 32'h00FFFF, 32'h00FF00,
                32'hFF00FF, 32'hFF0000, 32'h0000FF, 32'h000000};
    return colours[px / (HA / 8)];
  endfunction

  function automatic exp_t build(input int p, input int cm, input bit ce_v, input bit fs_v);
    exp_t ex;
    int   va, vfp, vsy;
    va  = (cm != 0) ? VA1 : VA0;
    vfp = (cm != 0) ? VF1 : VF0;
    vsy = (cm != 0) ? VS1 : VS0;
    ex.x   = p % HT;
    ex.y   = p / HT;
    ex.hb  = (ex.x >= HA) ? 1 : 0;
    ex.vb  = (ex.y >= va) ? 1 : 0;
    ex.de  = (ex.hb == 0 && ex.vb == 0) ? 1 : 0;
    ex.hs  = (ex.x >= HA + HFP && ex.x < HA + HFP + HSY) ? 0 : 1;
    ex.vs  = (ex.y >= va + vfp && ex.y < va + vfp + vsy) ? 0 : 1;
    ex.ce  = ce_v ? 1 : 0;
    ex.fs  = fs_v ? 1 : 0;
    ex.cm  = cm;
    ex.rgb = (ex.de != 0) ? bar_rgb(ex.x) : 0;
    return ex;
  endfunction

  always @(posedge clk) begin
    if (!reset_in) begin
      m_e  = 0;
      m_p  = HT * VT0 - 1;
      m_cm = 0;
      m_ce = 1'b0;
      m_fs = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (m_ce) begin
        if (m_p == HT * vtot(m_cm) - 1) begin
          m_p  = 0;
          m_cm = (mode === 1'b1) ? 1 : 0;
          m_fs = 1'b1;
        end else begin
          m_p++;
        end
      end
      m_e++;
      m_ce = ((m_e % CD) == 0);
    end
    q.push_back(build(m_p, m_cm, m_ce, m_fs));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t ex;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'(q.size()), 32'd1);
    end else begin
      ex = q.pop_front();
      chk("ce_pixel",    32'(ce_pixel),    32'(ex.ce));
      chk("x",           32'(x),           32'(ex.x));
      chk("y",           32'(y),           32'(ex.y));
      chk("hs",          32'(hs),          32'(ex.hs));
      chk("vs",          32'(vs),          32'(ex.vs));
      chk("hblank",      32'(hblank),      32'(ex.hb));
      chk("vblank",      32'(vblank),      32'(ex.vb));
      chk("de",          32'(de),          32'(ex.de));
      chk("frame_start", 32'(frame_start), 32'(ex.fs));
      chk("cur_mode",    32'(cur_mode),    32'(ex.cm));
`ifdef VIDEO_TIMING_TESTPAT_EN
      chk("rgb",         32'({r, g, b}),   32'(ex.rgb));
`endif
    end
  end

  // Asynchronous reset must take effect before any clock edge.
  task automatic async_reset_check();
    reset_in = 1'b0;
    #1;
    chk("rst_x",   32'(x),           32'(HT - 1));
    chk("rst_y",   32'(y),           32'(VT0 - 1));
    chk("rst_ce",  32'(ce_pixel),    32'd0);
    chk("rst_fs",  32'(frame_start), 32'd0);
    chk("rst_cm",  32'(cur_mode),    32'd0);
    chk("rst_blk", 32'({hblank, vblank, de}), 32'b110);
    chk("rst_sync", 32'({hs, vs}),   32'b11);
    repeat (3) @(negedge clk);
    #1 reset_in = 1'b1;
  endtask

  initial begin
    mode     = 1'b0;
    reset_in = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_in = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      #1;
      if (cyc == 4000 || cyc == 8500 || $urandom_range(0, 3999) == 0) begin
        async_reset_check();
      end else if ($urandom_range(0, 399) == 0) begin
        mode = ~mode;
      end else if ($urandom_range(0, 499) == 0) begin
        mode = ~mode;
        @(negedge clk);
        #1 mode = ~mode;
      end
    end
    repeat (2) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
